// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer slice.
// Default widths and the sequencer state encoding.
package mac_pkg;

   localparam int DATA_W = 4;
   localparam int ACC_W  = 12;
   localparam int LEN_W  = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/mac_datapath.sv
// Multiply-accumulate datapath: registered product, valid pipe bit,
// wrapping accumulator and sticky carry-out flag.
import mac_pkg::*;

module mac_datapath #(
   parameter int DATA_W = mac_pkg::DATA_W,
   parameter int ACC_W  = mac_pkg::ACC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc,
   output logic              ovf
);

   localparam int PROD_W = 2 * DATA_W;

   logic [PROD_W-1:0] prod;
   logic              prod_valid;
   logic [ACC_W:0]    sum;

   // Extra top bit of the sum is the carry out of the ACC_W-bit add.
   assign sum = {1'b0, acc} + (ACC_W+1)'(prod);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         prod       <= '0;
         prod_valid <= 1'b0;
         acc        <= '0;
         ovf        <= 1'b0;
      end else if (abort) begin
         prod_valid <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         prod_valid <= in_valid;
         if (in_valid) begin
            prod <= {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
         end
         if (prod_valid) begin
            acc <= sum[ACC_W-1:0];
            if (sum[ACC_W]) begin
               ovf <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mac_sequencer.sv
// Job sequencer: accepts a length, streams operand pairs into the
// datapath, waits one drain cycle and hands out the accumulated result.
import mac_pkg::*;

module mac_sequencer #(
   parameter int DATA_W = mac_pkg::DATA_W,
   parameter int ACC_W  = mac_pkg::ACC_W,
   parameter int LEN_W  = mac_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              abort,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic              res_ovf,
   output logic              busy,
   output logic              finish
);

   state_t           state;
   state_t           state_next;
   logic [LEN_W-1:0] cnt;
   logic             kill;
   logic             op_fire;
   logic             clr;

   // Abort only has meaning while a job is in flight.
   assign kill    = abort && (state != S_IDLE);
   assign op_fire = op_valid && op_ready && !kill;
   assign clr     = (state == S_CLEAR);
   assign busy    = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (cmd_valid && cmd_ready) begin
         cnt <= cmd_len;
      end else if (op_fire) begin
         cnt <= cnt - 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      op_ready   = 1'b0;
      res_valid  = 1'b0;
      finish     = 1'b0;
      unique case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_next = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_next = (cnt != '0) ? S_RUN : S_DONE;
         end
         S_RUN: begin
            op_ready = 1'b1;
            if (op_valid && cnt == LEN_W'(1)) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            state_next = S_DONE;
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_next = S_IDLE;
               finish     = !abort && !rst;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      if (kill) begin
         state_next = S_IDLE;
      end
   end

   mac_datapath #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_datapath (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .abort    (kill),
      .in_valid (op_fire),
      .a        (op_a),
      .b        (op_b),
      .acc      (res_data),
      .ovf      (res_ovf)
   );

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: driver pushes expected results
// from a sum-of-products model, a negedge monitor pops and compares.
module tb_mac_sequencer;

   localparam int DW = 4;
   localparam int AW = 12;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [LW-1:0] cmd_len = '0;
   logic          abort = 1'b0;
   logic          op_valid = 1'b0;
   logic          op_ready;
   logic [DW-1:0] op_a = '0;
   logic [DW-1:0] op_b = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [AW-1:0] res_data;
   logic          res_ovf;
   logic          busy;
   logic          finish;

   mac_sequencer #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_len   (cmd_len),
      .abort     (abort),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_ovf   (res_ovf),
      .busy      (busy),
      .finish    (finish)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit armed = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] data;
      bit            ovf;
      int            due;
   } exp_t;

   exp_t sb[$];
   int   ja[$];
   int   jb[$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic bad(input string name);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Monitor: result timing, hold stability, payload and finish pulse.
   logic          prev_rv = 1'b0;
   logic          prev_hold = 1'b0;
   logic [AW-1:0] prev_d;
   logic          prev_o;

   always @(negedge clk) begin
      logic hs;
      logic kill;
      exp_t e;
      if (armed) begin
         hs   = res_valid && res_ready && !abort && !rst;
         kill = res_valid && (abort || rst);
         chk("finish", finish, hs);
         if (res_valid && !prev_rv) begin
            if (sb.size() == 0) bad("unexpected_res_valid");
            else chk("res_latency", cyc, sb[0].due);
         end
         if (prev_hold) begin
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, prev_d);
            chk("hold_ovf", res_ovf, prev_o);
         end
         if (hs) begin
            if (sb.size() == 0) begin
               bad("handshake_without_job");
            end else begin
               e = sb.pop_front();
               chk("res_data", res_data, e.data);
               chk("res_ovf", res_ovf, e.ovf);
            end
         end else if (kill && sb.size() > 0) begin
            void'(sb.pop_front());
         end
         prev_rv   = res_valid;
         prev_hold = res_valid && !hs && !kill;
         prev_d    = res_data;
         prev_o    = res_ovf;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [63:0] sum, input int due);
      exp_t e;
      e.data = sum[AW-1:0];
      e.ovf  = (sum >= 64'(1 << AW));
      e.due  = due;
      sb.push_back(e);
   endtask

   task automatic do_kill(input bit use_rst);
      op_valid = 1'b0;
      if (use_rst) rst = 1'b1;
      else abort = 1'b1;
      step();
      rst   = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      chk("kill_busy", busy, 0);
      chk("kill_res_valid", res_valid, 0);
      step();
   endtask

   // abort_at: pair index before which the job is killed; len means
   // abort together with the result handshake; -1 means never.
   task automatic run_job(input int gmin, input int gmax,
                          input int abort_at, input bit use_rst,
                          input int rdy_wait, input bit cmd_in_done);
      int          len;
      int          c0;
      int          n;
      logic [63:0] sum;
      len = ja.size();
      sum = 0;
      for (int i = 0; i < len; i++) sum += 64'(ja[i] * jb[i]);

      cmd_valid = 1'b1;
      cmd_len   = LW'(len);
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 20) begin
         step();
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         bad("cmd_timeout");
         cmd_valid = 1'b0;
         return;
      end
      c0 = cyc;
      step();
      cmd_valid = 1'b0;
      if (len == 0) push_exp(sum, c0 + 2);

      for (int i = 0; i < len; i++) begin
         if (i == abort_at) begin
            do_kill(use_rst);
            return;
         end
         repeat ($urandom_range(gmax, gmin)) step();
         op_valid = 1'b1;
         op_a = DW'(ja[i]);
         op_b = DW'(jb[i]);
         n = 0;
         @(negedge clk);
         while (!op_ready && n < 20) begin
            step();
            @(negedge clk);
            n++;
         end
         if (!op_ready) begin
            bad("op_timeout");
            op_valid = 1'b0;
            return;
         end
         if (i == len - 1) push_exp(sum, cyc + 2);
         step();
         op_valid = 1'b0;
      end

      n = 0;
      @(negedge clk);
      while (!res_valid && n < 10) begin
         chk("op_ready_idle", op_ready, 0);
         step();
         @(negedge clk);
         n++;
      end
      if (!res_valid) begin
         bad("res_timeout");
         return;
      end
      repeat (rdy_wait) begin
         cmd_valid = cmd_in_done;
         chk("cmd_ready_done", cmd_ready, 0);
         step();
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      abort     = (abort_at == len);
      step();
      res_ready = 1'b0;
      abort     = 1'b0;
      @(negedge clk);
      chk("post_busy", busy, 0);
      chk("post_res_valid", res_valid, 0);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      int ab;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_op_ready", op_ready, 0);
      chk("rst_finish", finish, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_ovf", res_ovf, 0);
      armed = 1'b1;
      step();

      ja = '{2, 4, 1}; jb = '{3, 5, 7};
      run_job(0, 0, -1, 0, 0, 0);
      run_job(2, 2, -1, 0, 0, 0);

      ja = {}; jb = {};
      run_job(0, 0, -1, 0, 0, 0);

      ja = {}; jb = {};
      for (int i = 0; i < 20; i++) begin
         ja.push_back(15);
         jb.push_back(15);
      end
      run_job(0, 0, -1, 0, 0, 0);
      ja = '{1}; jb = '{1};
      run_job(0, 0, -1, 0, 0, 0);

      ja = '{2, 4, 1}; jb = '{3, 5, 7};
      run_job(0, 1, -1, 0, 5, 1);

      ja = '{5, 6, 7, 8}; jb = '{9, 10, 11, 12};
      run_job(0, 0, 2, 0, 0, 0);
      run_job(0, 0, 2, 1, 0, 0);
      ja = '{3}; jb = '{3};
      run_job(0, 0, -1, 0, 0, 0);

      ja = '{9, 9}; jb = '{9, 9};
      run_job(0, 0, 2, 0, 0, 0);
      ja = '{3}; jb = '{3};
      run_job(0, 0, -1, 0, 0, 0);

      for (int j = 0; j < 40; j++) begin
         len = $urandom_range(24, 0);
         ja = {}; jb = {};
         for (int i = 0; i < len; i++) begin
            ja.push_back($urandom_range(15, 0));
            jb.push_back($urandom_range(15, 0));
         end
         ab = ($urandom_range(7, 0) == 0) ? $urandom_range(len, 0) : -1;
         run_job(0, $urandom_range(2, 0), ab,
                 (ab >= 0 && ab < len) ? 1'($urandom_range(1, 0)) : 1'b0,
                 $urandom_range(3, 0), 1'($urandom_range(1, 0)));
      end

      repeat (5) step();
      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
